arb8_sched: RTL and testbench

ARB8_SCHED -- requirements
Module: arb8_sched

---
 rtl/arb_pkg.sv | 27 ++
 rtl/arb8_sched_if.sv | 28 ++
 rtl/prio_enc8_rot.sv | 34 +++
 rtl/arb8_sched.sv | 97 +++++++++
 tb/tb_arb8_sched.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way grant arbiter.
//   NUM_REQ / IDX_W : requester count and index width
//   HOLD_W          : hold counter width (covers MAX_HOLD up to 255)
//   arb_state_e     : arbiter FSM states
//   gnt_t           : registered grant outputs
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               valid;
    logic [IDX_W-1:0]   idx;
    logic [NUM_REQ-1:0] onehot;
    logic               timeout;
  } gnt_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/arb8_sched_if.sv
// Requester/arbiter bus for arb8_sched.
//   req_n      : active-low requests, one bit per requester
//   done       : one-cycle end-of-transaction pulse from the granted requester
//   gnt_valid  : grant held
//   gnt_idx    : binary index of the granted requester (0 when idle)
//   gnt_onehot : one-hot grant (0 when idle)
//   timeout    : one-cycle pulse after a forced release
// master = requester side, slave = arbiter side.
interface arb8_sched_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req_n;
  logic               done;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               timeout;

  modport master (
    output req_n, done,
    input  gnt_valid, gnt_idx, gnt_onehot, timeout
  );

  modport slave (
    input  req_n, done,
    output gnt_valid, gnt_idx, gnt_onehot, timeout
  );
endinterface

// File: rtl/prio_enc8_rot.sv
// Rotating active-low priority encoder.
//   req_n : active-low request vector
//   ptr   : search start position (search goes upward, wrapping 7->0)
//   idx   : index of the first low req_n bit at or above ptr
//   any   : at least one request low
// Purely combinational.
module prio_enc8_rot
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_n,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  always_comb begin
    req = ~req_n;
    // Doubling the vector makes the right-rotate a plain shift: bit 0 of
    // rot is requester ptr, bit 1 is ptr+1, and so on.
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    // Scan high to low so the lowest set offset wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = ptr + off; // wraps mod 8 by width
    any = |req;
  end
endmodule

// File: rtl/arb8_sched.sv
// 8-requester grant scheduler with hold limit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : arb8_sched_if.slave (requests/done in, registered grant out)
// Parameters:
//   MAX_HOLD : cycles a grant may be held before forced release (2..255)
//   RR_MODE  : 1 = round-robin from ptr, 0 = fixed priority (index 0 highest)
// Grant lifecycle: IDLE samples requests, GRANT holds until done / abandon /
// hold limit, RELEASE is one dead cycle before sampling resumes.
module arb8_sched
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int RR_MODE  = 1
) (
  input logic         clk,
  input logic         rst,
  arb8_sched_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q,   ptr_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  gnt_t              gnt_q,   gnt_d;

  logic [IDX_W-1:0]  enc_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic              abandon;
  logic              forced;

  // Fixed priority is just a search that always starts at 0.
  assign enc_ptr = (RR_MODE != 0) ? ptr_q : '0;

  prio_enc8_rot u_enc (
    .req_n (bus.req_n),
    .ptr   (enc_ptr),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Only meaningful in GRANT; gnt_q.idx is stable for the whole grant.
  assign abandon = bus.req_n[gnt_q.idx];
  assign forced  = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    gnt_d         = gnt_q;
    gnt_d.timeout = 1'b0; // pulse: cleared unless set below
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d      = GRANT;
          gnt_d.valid  = 1'b1;
          gnt_d.idx    = win_idx;
          gnt_d.onehot = idx2onehot(win_idx);
          ptr_d        = win_idx + 1'b1; // wraps 7->0 by width
          hold_d       = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        // All exit causes collapse into one release; timeout only when the
        // limit forced it and the requester did not finish that same cycle.
        if (bus.done || abandon || forced) begin
          state_d       = RELEASE;
          gnt_d.valid   = 1'b0;
          gnt_d.idx     = '0;
          gnt_d.onehot  = '0;
          gnt_d.timeout = forced && !bus.done;
          hold_d        = '0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_valid  = gnt_q.valid;
  assign bus.gnt_idx    = gnt_q.idx;
  assign bus.gnt_onehot = gnt_q.onehot;
  assign bus.timeout    = gnt_q.timeout;
endmodule

// File: tb/tb_arb8_sched.sv
// Bench for arb8_sched: two instances share req_n/rst with separate done.
//   dut0: RR_MODE=1, MAX_HOLD=4   dut1: RR_MODE=0, MAX_HOLD=5
// A transaction-level model (owner / cycles held / dead time / pointer)
// predicts every output each cycle; directed steps add hand-derived checks.
module tb_arb8_sched;
  import arb_pkg::*;

  localparam int MAXH0 = 4;
  localparam int MAXH1 = 5;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arb8_sched_if bus0 ();
  arb8_sched_if bus1 ();

  arb8_sched #(.MAX_HOLD(MAXH0), .RR_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(bus0));
  arb8_sched #(.MAX_HOLD(MAXH1), .RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(bus1));

  // Model state per instance: current owner (-1 none), cycles the grant has
  // been visible, dead cycles left before requests are looked at, rr pointer.
  int m_owner[2];
  int m_cyc[2];
  int m_dead[2];
  int m_ptr[2];
  bit m_to[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int k, input logic [7:0] r);
    int base;
    base = (k == 0) ? m_ptr[k] : 0;
    for (int j = 0; j < 8; j++)
      if (!r[(base + j) % 8]) return (base + j) % 8;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [7:0] r, input logic d, input logic rs);
    int maxh;
    int w;
    bit forced;
    maxh = (k == 0) ? MAXH0 : MAXH1;
    if (rs) begin
      m_owner[k] = -1; m_cyc[k] = 0; m_dead[k] = 0; m_ptr[k] = 0; m_to[k] = 0;
    end else if (m_owner[k] >= 0) begin
      forced  = (m_cyc[k] == maxh);
      m_to[k] = 0;
      if (d || r[m_owner[k]] || forced) begin
        m_to[k]    = forced && !d;
        m_owner[k] = -1;
        m_dead[k]  = 1;
      end else begin
        m_cyc[k]++;
      end
    end else begin
      m_to[k] = 0;
      if (m_dead[k] > 0) m_dead[k]--;
      else begin
        w = pick(k, r);
        if (w >= 0) begin
          m_owner[k] = w; m_cyc[k] = 1; m_ptr[k] = (w + 1) % 8;
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_of(input int k);
    logic       v;
    logic [2:0] i;
    logic [7:0] oh;
    v  = (m_owner[k] >= 0);
    i  = v ? 3'(m_owner[k]) : 3'd0;
    oh = v ? (8'd1 << m_owner[k]) : 8'd0;
    return {v, i, oh, m_to[k]};
  endfunction

  task automatic cyc(input logic [7:0] r, input logic d0, input logic d1, input logic rs);
    bus0.req_n = r; bus1.req_n = r;
    bus0.done  = d0; bus1.done = d1;
    rst = rs;
    @(posedge clk);
    model_step(0, r, d0, rs);
    model_step(1, r, d1, rs);
    #1;
    chk("dut0_model", {bus0.gnt_valid, bus0.gnt_idx, bus0.gnt_onehot, bus0.timeout}, exp_of(0));
    chk("dut1_model", {bus1.gnt_valid, bus1.gnt_idx, bus1.gnt_onehot, bus1.timeout}, exp_of(1));
  endtask

  // Advance with constant inputs until dut0 holds a grant; returns cycles used.
  task automatic wait_gnt0(input logic [7:0] r, output int n);
    n = 0;
    while (bus0.gnt_valid !== 1'b1 && n < 20) begin
      cyc(r, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_gnt0_bound", 32'(n < 20), 32'd1);
  endtask

  initial begin
    int n;
    int hi;
    logic [7:0] r;

    // Reset and idle
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", bus0.gnt_valid, 0);
    chk("rst_idx", bus0.gnt_idx, 0);
    chk("rst_onehot", bus0.gnt_onehot, 0);
    chk("rst_timeout", bus0.timeout, 0);
    for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b1, 1'b1, 1'b0);
    chk("idle_no_req", bus0.gnt_valid, 0);

    // Round-robin walk with all requesting, done in every grant's first cycle
    for (int g = 0; g < 9; g++) begin
      wait_gnt0(8'h00, n);
      chk("rr_seq_idx", bus0.gnt_idx, g % 8);
      chk("rr_gap", n, (g == 0) ? 1 : 2);
      cyc(8'h00, 1'b1, 1'b1, 1'b0);
      chk("rr_done_drop", bus0.gnt_valid, 0);
    end

    // Fixed priority always picks lowest low bit
    cyc(8'h56, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (bus1.gnt_valid !== 1'b1 && n < 20) begin
        cyc(8'h56, 1'b0, 1'b0, 1'b0);
        n++;
      end
      chk("fp_idx", bus1.gnt_idx, 0);
      chk("fp_onehot", bus1.gnt_onehot, 8'h01);
      cyc(8'h56, 1'b0, 1'b1, 1'b0);
    end

    // Forced release after MAX_HOLD=4 cycles on dut0, then regrant to 3
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_gnt0(8'hF7, n);
    chk("hold_idx", bus0.gnt_idx, 3);
    hi = 1;
    while (bus0.gnt_valid === 1'b1 && hi < 20) begin
      cyc(8'hF7, 1'b0, 1'b0, 1'b0);
      if (bus0.gnt_valid === 1'b1) hi++;
    end
    chk("hold_cycles", hi, MAXH0);
    chk("hold_timeout", bus0.timeout, 1);
    cyc(8'hF7, 1'b0, 1'b0, 1'b0);
    chk("hold_timeout_pulse", bus0.timeout, 0);
    chk("hold_dead", bus0.gnt_valid, 0);
    cyc(8'hF7, 1'b0, 1'b0, 1'b0);
    chk("hold_regrant", {bus0.gnt_valid, bus0.gnt_idx}, {1'b1, 3'd3});

    // Abandon by requester 5
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_gnt0(8'hDF, n);
    chk("abandon_idx", bus0.gnt_idx, 5);
    cyc(8'hFD, 1'b0, 1'b0, 1'b0);
    chk("abandon_drop", bus0.gnt_valid, 0);
    chk("abandon_no_to", bus0.timeout, 0);

    // Non-granted request changes during a grant leave it untouched
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_gnt0(8'hFB, n);
    cyc(8'hF8, 1'b0, 1'b0, 1'b0);
    cyc(8'h7B, 1'b0, 1'b0, 1'b0);
    chk("other_req_stable", {bus0.gnt_valid, bus0.gnt_onehot}, {1'b1, 8'h04});

    // Reset mid-grant to 6
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_gnt0(8'hBF, n);
    chk("rst_mid_idx", bus0.gnt_idx, 6);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_clear", {bus0.gnt_valid, bus0.gnt_idx, bus0.gnt_onehot, bus0.timeout}, 13'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_regrant", {bus0.gnt_valid, bus0.gnt_idx}, {1'b1, 3'd0});

    // done coincides with the forced limit
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_gnt0(8'hF7, n);
    for (int i = 0; i < MAXH0 - 1; i++) cyc(8'hF7, 1'b0, 1'b0, 1'b0);
    chk("coinc_still_held", bus0.gnt_valid, 1);
    cyc(8'hF7, 1'b1, 1'b0, 1'b0);
    chk("coinc_drop", bus0.gnt_valid, 0);
    chk("coinc_no_to", bus0.timeout, 0);
    cyc(8'hF7, 1'b0, 1'b0, 1'b0);
    chk("coinc_single", {bus0.gnt_valid, bus0.timeout}, 2'b00);

    // Random traffic against the model
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'hFF;
      else if ($urandom_range(0, 3) == 0) r = r | 8'hF0;
      cyc(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
